// File: rtl/router_fsm.sv
// Packet-sequencing Moore FSM for the 1x3 router: decodes the header address and sequences register-stage strobes.
// Optional WTE timeout drop enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm #(
   parameter int WAIT_LIMIT = 32
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy,
   output logic       pkt_drop
);

   localparam logic [2:0] DA  = 3'd0;
   localparam logic [2:0] LFD = 3'd1;
   localparam logic [2:0] LD  = 3'd2;
   localparam logic [2:0] FFS = 3'd3;
   localparam logic [2:0] LAF = 3'd4;
   localparam logic [2:0] LP  = 3'd5;
   localparam logic [2:0] CPE = 3'd6;
   localparam logic [2:0] WTE = 3'd7;

   logic [2:0] state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic [1:0] sel;
   logic       sel_empty, sel_srst, header_ok, timeout;

   // The header byte itself selects the FIFO while decoding; afterwards the latched address does.
   always_comb begin
      sel       = (state_q == DA) ? data_in : addr_q;
      header_ok = pkt_valid && (data_in != 2'd3);
      sel_empty = 1'b0;
      sel_srst  = 1'b0;
      case (sel)
         2'd0:    begin sel_empty = fifo_empty_0; sel_srst = soft_reset_0; end
         2'd1:    begin sel_empty = fifo_empty_1; sel_srst = soft_reset_1; end
         2'd2:    begin sel_empty = fifo_empty_2; sel_srst = soft_reset_2; end
         default: begin sel_empty = 1'b0;         sel_srst = 1'b0;         end
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      if (state_q == DA && header_ok) addr_d = data_in;
   end

   always_comb begin
      state_d = state_q;
      if (sel_srst) begin
         state_d = DA;
      end else begin
         case (state_q)
            DA:      if (header_ok) state_d = sel_empty ? LFD : WTE;
            LFD:     state_d = LD;
            LD: begin
               if (fifo_full)       state_d = FFS;
               else if (!pkt_valid) state_d = LP;
            end
            FFS:     if (!fifo_full) state_d = LAF;
            LAF: begin
               if (parity_done)        state_d = DA;
               else if (low_pkt_valid) state_d = LP;
               else                    state_d = LD;
            end
            LP:      state_d = CPE;
            CPE:     state_d = fifo_full ? FFS : DA;
            WTE: begin
               if (sel_empty)    state_d = LFD;
               else if (timeout) state_d = DA;
            end
            default: state_d = DA;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= DA;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

`ifdef ROUTER_FSM_TIMEOUT_EN
   logic [5:0] cnt_q, cnt_d;
   logic       drop_q, drop_d;

   always_comb begin
      timeout = (state_q == WTE) && (cnt_q == 6'(WAIT_LIMIT - 1)) && !sel_empty;
      drop_d  = timeout && !sel_srst;
      cnt_d   = (state_q == WTE && state_d == WTE) ? cnt_q + 6'd1 : 6'd0;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q  <= 6'd0;
         drop_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   assign pkt_drop = drop_q;
`else
   assign timeout  = 1'b0;
   assign pkt_drop = 1'b0;
`endif

   assign detect_add    = (state_q == DA);
   assign lfd_state     = (state_q == LFD);
   assign ld_state      = (state_q == LD);
   assign laf_state     = (state_q == LAF);
   assign full_state    = (state_q == FFS);
   assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
   assign rst_int_reg   = (state_q == CPE);
   assign busy          = (state_q != DA) && (state_q != LD);

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: expected output vectors are queued per stimulus cycle and compared after each edge.
module tb_router_fsm;

   logic clock = 1'b0;
   logic resetn;
   logic pkt_valid;
   logic [1:0] data_in;
   logic fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic soft_reset_0, soft_reset_1, soft_reset_2;
   logic parity_done, low_pkt_valid;
   logic detect_add, lfd_state, ld_state, laf_state, full_state;
   logic write_enb_reg, rst_int_reg, busy, pkt_drop;

   int passed = 0;
   int total  = 0;

   logic [8:0] exp_q[$];
   logic [8:0] act_q[$];
   string      nam_q[$];

   localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

   router_fsm dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
      .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
      .busy(busy), .pkt_drop(pkt_drop)
   );

   always #5 clock = ~clock;

   // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy, pkt_drop}
   function automatic logic [8:0] exp_out(int s, logic drop);
      logic [8:0] v;
      case (s)
         S_DA:    v = 9'b1_0000_0000;
         S_LFD:   v = 9'b0_1000_0010;
         S_LD:    v = 9'b0_0100_1000;
         S_LAF:   v = 9'b0_0010_1010;
         S_FFS:   v = 9'b0_0001_0010;
         S_LP:    v = 9'b0_0000_1010;
         S_CPE:   v = 9'b0_0000_0110;
         default: v = 9'b0_0000_0010;
      endcase
      v[0] = drop;
      return v;
   endfunction

   task automatic tick(input string name, input int s, input logic drop);
      exp_q.push_back(exp_out(s, drop));
      nam_q.push_back(name);
      @(posedge clock);
      #1;
      act_q.push_back({detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_enb_reg, rst_int_reg, busy, pkt_drop});
   endtask

   task automatic idle_inputs();
      pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         {pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2} = 7'($urandom);
         {soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid} = 5'($urandom);
         tick("reset", S_DA, 1'b0);
      end
      idle_inputs();
      resetn = 1'b1;
      tick("post_reset_idle", S_DA, 1'b0);
      while (exp_q.size() > 0) begin
         logic [8:0] e, a; string n;
         e = exp_q.pop_front(); a = act_q.pop_front(); n = nam_q.pop_front();
         total++;
         if (a !== e) $display("FAIL %s: outputs got %b expected %b", n, a, e);
         else passed++;
      end
   endtask

   task automatic test_normal_packet();
      idle_inputs();
      pkt_valid = 1'b1; data_in = 2'd1;
      tick("np_header", S_LFD, 1'b0);
      data_in = 2'd3;
      for (int i = 0; i < 4; i++) tick("np_payload", S_LD, 1'b0);
      pkt_valid = 1'b0;
      tick("np_parity", S_LP, 1'b0);
      tick("np_check", S_CPE, 1'b0);
      tick("np_done", S_DA, 1'b0);
      while (exp_q.size() > 0) begin
         logic [8:0] e, a; string n;
         e = exp_q.pop_front(); a = act_q.pop_front(); n = nam_q.pop_front();
         total++;
         if (a !== e) $display("FAIL %s: outputs got %b expected %b", n, a, e);
         else passed++;
      end
   endtask

   task automatic test_full_mid_packet();
      for (int v = 0; v < 3; v++) begin
         idle_inputs();
         pkt_valid = 1'b1; data_in = 2'd0;
         tick("fm_header", S_LFD, 1'b0);
         tick("fm_lfd_to_ld", S_LD, 1'b0);
         fifo_full = 1'b1;
         for (int i = 0; i < 3; i++) tick("fm_full", S_FFS, 1'b0);
         fifo_full = 1'b0;
         tick("fm_laf", S_LAF, 1'b0);
         if (v == 0) begin
            tick("fm_laf_to_ld", S_LD, 1'b0);
            pkt_valid = 1'b0;
            tick("fm_lp", S_LP, 1'b0);
            fifo_full = 1'b1;
            tick("fm_cpe", S_CPE, 1'b0);
            tick("fm_cpe_full", S_FFS, 1'b0);
            fifo_full = 1'b0; parity_done = 1'b1;
            tick("fm_laf2", S_LAF, 1'b0);
            tick("fm_laf_parity_done", S_DA, 1'b0);
         end else if (v == 1) begin
            low_pkt_valid = 1'b1; pkt_valid = 1'b0;
            tick("fm_laf_to_lp", S_LP, 1'b0);
            tick("fm_cpe_b", S_CPE, 1'b0);
            tick("fm_da_b", S_DA, 1'b0);
         end else begin
            parity_done = 1'b1; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
            tick("fm_parity_over_low", S_DA, 1'b0);
         end
      end
      while (exp_q.size() > 0) begin
         logic [8:0] e, a; string n;
         e = exp_q.pop_front(); a = act_q.pop_front(); n = nam_q.pop_front();
         total++;
         if (a !== e) $display("FAIL %s: outputs got %b expected %b", n, a, e);
         else passed++;
      end
   endtask

   task automatic test_wait_and_soft_reset();
      idle_inputs();
      fifo_empty_2 = 1'b0;
      pkt_valid = 1'b1; data_in = 2'd2;
      tick("wt_header", S_WTE, 1'b0);
      data_in = 2'd0;
      for (int i = 0; i < 4; i++) tick("wt_wait", S_WTE, 1'b0);
      soft_reset_0 = 1'b1;
      tick("wt_other_srst", S_WTE, 1'b0);
      soft_reset_0 = 1'b0;
      fifo_empty_2 = 1'b1;
      tick("wt_to_lfd", S_LFD, 1'b0);
      soft_reset_2 = 1'b1;
      tick("wt_srst_own", S_DA, 1'b0);
      soft_reset_2 = 1'b0;
      data_in = 2'd3;
      tick("addr3_ignored", S_DA, 1'b0);
      tick("addr3_ignored2", S_DA, 1'b0);
      data_in = 2'd0;
      tick("sr_header", S_LFD, 1'b0);
      tick("sr_ld", S_LD, 1'b0);
      soft_reset_1 = 1'b1;
      tick("sr_other_ignored", S_LD, 1'b0);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      tick("sr_own", S_DA, 1'b0);
      soft_reset_0 = 1'b0; pkt_valid = 1'b0;
      tick("sr_idle", S_DA, 1'b0);
      while (exp_q.size() > 0) begin
         logic [8:0] e, a; string n;
         e = exp_q.pop_front(); a = act_q.pop_front(); n = nam_q.pop_front();
         total++;
         if (a !== e) $display("FAIL %s: outputs got %b expected %b", n, a, e);
         else passed++;
      end
   endtask

   task automatic test_timeout();
      idle_inputs();
      fifo_empty_0 = 1'b0;
      pkt_valid = 1'b1; data_in = 2'd0;
      tick("to_header", S_WTE, 1'b0);
      pkt_valid = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
      for (int i = 0; i < 31; i++) tick("to_wait", S_WTE, 1'b0);
      tick("to_drop", S_DA, 1'b1);
      tick("to_drop_one_cycle", S_DA, 1'b0);
      pkt_valid = 1'b1;
      tick("to_header2", S_WTE, 1'b0);
      pkt_valid = 1'b0;
      for (int i = 0; i < 30; i++) tick("to_wait2", S_WTE, 1'b0);
      fifo_empty_0 = 1'b1;
      tick("to_empty_wins", S_LFD, 1'b0);
`else
      for (int i = 0; i < 100; i++) tick("to_wait_forever", S_WTE, 1'b0);
      fifo_empty_0 = 1'b1;
      tick("to_released", S_LFD, 1'b0);
`endif
      tick("to_ld", S_LD, 1'b0);
      tick("to_lp", S_LP, 1'b0);
      tick("to_cpe", S_CPE, 1'b0);
      tick("to_da", S_DA, 1'b0);
      while (exp_q.size() > 0) begin
         logic [8:0] e, a; string n;
         e = exp_q.pop_front(); a = act_q.pop_front(); n = nam_q.pop_front();
         total++;
         if (a !== e) $display("FAIL %s: outputs got %b expected %b", n, a, e);
         else passed++;
      end
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      #1;
      test_reset();
      test_normal_packet();
      test_full_mid_packet();
      test_wait_and_soft_reset();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-sequencing controller for the 1x3 router.
- Watches the incoming byte stream (pkt_valid, 2-bit address field of the header) and the full/empty/soft-reset status of the three output FIFOs.
- Generates the control strobes that drive the register stage and the synchronizer: detect_add, write_enb_reg, lfd/ld/laf/full state flags, rst_int_reg, busy.
- Sits between the input port and the register/synchronizer blocks; one instance per router.

Parameters:
- WAIT_LIMIT, 32, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped. Used only with ROUTER_FSM_TIMEOUT_EN.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- resetn  input  1  synchronous, active-low reset
- pkt_valid  input  1  high while packet bytes (header+payload) are on the input bus
- data_in  input  2  address field (bits [1:0] of the header byte); 0/1/2 valid, 3 invalid
- fifo_full  input  1  full flag of the currently addressed FIFO
- fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  FIFO empty flags
- soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-FIFO soft resets (read timeout)
- parity_done  input  1  parity byte captured by the register stage
- low_pkt_valid  input  1  pkt_valid fell while the FIFO was full
- detect_add  output  1  high in DECODE_ADDRESS
- lfd_state  output  1  high in LOAD_FIRST_DATA
- ld_state  output  1  high in LOAD_DATA
- laf_state  output  1  high in LOAD_AFTER_FULL
- full_state  output  1  high in FIFO_FULL_STATE
- write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR
- busy  output  1  high in every state except DECODE_ADDRESS and LOAD_DATA
- pkt_drop  output  1  one-cycle pulse on timeout drop; constant 0 without ROUTER_FSM_TIMEOUT_EN

Behaviour:
- Moore FSM, 3-bit state register, 8 states. All outputs are decoded from the state register only; no input-to-output combinational path.
- Reset: resetn=0 at a clock edge forces state=DECODE_ADDRESS, addr_q=0, timeout counter=0.
  - Outputs after reset: detect_add=1, all other outputs 0.
- addr_q (2 bits) loads data_in on any DA cycle where pkt_valid=1 and data_in!=3.
  - The "addressed" FIFO is selected by data_in in the DA capture cycle and by addr_q in all other states.
- Transition priority: resetn, then soft reset of the addressed FIFO (soft_reset_[addr_q]=1 forces DA from any state), then the state table below.
  - Soft resets of non-addressed FIFOs are ignored.
- DECODE_ADDRESS (DA):
  - pkt_valid=1, data_in!=3, fifo_empty_[data_in]=1 -> LFD.
  - pkt_valid=1, data_in!=3, fifo_empty_[data_in]=0 -> WTE.
  - Otherwise stay. Address 3 is ignored and the byte is not latched.
- LOAD_FIRST_DATA (LFD): unconditionally -> LD (exactly 1 cycle).
- LOAD_DATA (LD): fifo_full=1 -> FFS; else pkt_valid=0 -> LP; else stay. fifo_full takes priority over pkt_valid=0.
- FIFO_FULL_STATE (FFS): fifo_full=0 -> LAF; else stay.
- LOAD_AFTER_FULL (LAF):
  - parity_done=1 -> DA.
  - parity_done=0 and low_pkt_valid=1 -> LP.
  - parity_done=0 and low_pkt_valid=0 -> LD.
- LOAD_PARITY (LP): unconditionally -> CPE.
- CHECK_PARITY_ERROR (CPE): fifo_full=1 -> FFS; else -> DA.
- WAIT_TILL_EMPTY (WTE): fifo_empty_[addr_q]=1 -> LFD; else stay.
- Unused state encodings recover to DA on the next edge.

Optional Feature:
- ROUTER_FSM_TIMEOUT_EN defined:
  - A 6-bit counter increments on every WTE cycle and clears on any other state.
  - When the counter reaches WAIT_LIMIT-1 while still in WTE with the FIFO not empty: next state = DA, pkt_drop pulses 1 for that one transition cycle (registered, visible the cycle DA is entered), counter clears.
  - Empty on the same cycle wins: go to LFD, no drop.
- ROUTER_FSM_TIMEOUT_EN undefined:
  - No counter; WTE waits indefinitely; pkt_drop tied 0.

Test Plan:
- Reset: resetn=0 for 2 cycles with random inputs -> detect_add=1, write_enb_reg=0, busy=0, pkt_drop=0.
- Normal packet to FIFO 1, all FIFOs empty, fifo_full=0: pkt_valid=1, data_in=1 for 1 cycle, payload for 4 cycles, then pkt_valid=0 -> state trace DA,LFD,LD x4,LP,CPE,DA; write_enb_reg=1 for 5 cycles; rst_int_reg=1 for 1 cycle.
- Full mid-packet: in LD raise fifo_full for 3 cycles, then drop it with low_pkt_valid=0 -> FFS x3, LAF, LD; full_state=1 for 3 cycles; busy=1 in FFS and LAF. Repeat with low_pkt_valid=1 -> LAF, LP, CPE.
- Busy destination: fifo_empty_2=0, header data_in=2 -> WTE, busy=1; set fifo_empty_2=1 after 5 cycles -> LFD on next edge. Header data_in=3 -> stays in DA, addr_q unchanged.
- Soft reset: in LD for FIFO 0, assert soft_reset_0 -> DA next cycle. Assert soft_reset_1 instead -> no effect on state.
- Timeout (macro on, WAIT_LIMIT=32): header to FIFO 0 with fifo_empty_0=0 held -> 32 cycles in WTE, then DA with pkt_drop=1 for exactly one cycle. Macro off -> still in WTE after 100 cycles, pkt_drop=0.
